// File: rtl/lzrw1_compressor_core.sv
// Byte-serial LZRW1 compressor: hash-table match finder over a ring history, emitting literal/copy tokens.
// Optional statistics counters are built when LZRW1_COMP_STATS_EN is defined.
module lzrw1_compressor_core #(
  parameter int HISTORY_SIZE = 4096,
  parameter int HASH_BITS    = 10,
  parameter int MIN_MATCH    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_control,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
`ifdef LZRW1_COMP_STATS_EN
  ,
  output logic [31:0] stat_literals,
  output logic [31:0] stat_copies,
  output logic [31:0] stat_bytes_in
`endif
);

  localparam int AW = $clog2(HISTORY_SIZE);
  localparam logic [3:0] MIN_LEN = 4'(MIN_MATCH);

  typedef enum logic [3:0] {
    S_CLEAR, S_FILL, S_HASH, S_CHECK, S_VERIFY, S_EXT_ADDR,
    S_EXTEND, S_EMIT_LIT, S_EMIT_MATCH, S_DRAIN, S_DONE
  } state_t;

  state_t               state;
  logic [HASH_BITS-1:0] clr_idx;
  logic [AW-1:0]        pos;
  logic [1:0]           cnt;
  logic [1:0]           vcnt;
  logic [3:0]           len;
  logic                 last_seen;

  logic [7:0]           l0, l1, l2;
  logic [AW-1:0]        start, cand, offset;

  logic [7:0]           hist_mem [HISTORY_SIZE];
  logic [AW:0]          hash_mem [2**HASH_BITS];
  logic [7:0]           hist_rd_p1;
  logic [AW:0]          hash_rd_p1;

  logic [AW-1:0]        hist_raddr;
  logic                 hist_we;
  logic [HASH_BITS-1:0] hash_addr;
  logic                 hash_we;
  logic [AW:0]          hash_wdata;
  logic                 hash_hit;
  logic [AW-1:0]        hash_pos;
  logic                 hist_match;
  logic                 accept;
  logic [7:0]           vbyte;

  function automatic logic [HASH_BITS-1:0] hash3(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2);
    return HASH_BITS'({b0, 4'b0} ^ {2'b0, b1, 2'b0} ^ {4'b0, b2});
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign hash_hit   = hash_rd_p1[AW];
  assign hash_pos   = hash_rd_p1[AW-1:0];
  assign hist_match = (in_byte == hist_rd_p1);
  // During EXTEND the byte is only taken if it continues the match.
  assign in_ready   = (state == S_FILL) || (state == S_EXTEND && in_valid && hist_match);
  assign accept     = in_valid && in_ready;
  assign hist_we    = accept;

  always_comb begin
    hash_we    = 1'b0;
    hash_addr  = hash3(l0, l1, l2);
    hash_wdata = {1'b1, pos - AW'(3)};
    if (state == S_CLEAR) begin
      hash_we    = 1'b1;
      hash_addr  = clr_idx;
      hash_wdata = '0;
    end else if (state == S_HASH) begin
      hash_we    = 1'b1;
    end
  end

  always_comb begin
    hist_raddr = cand + AW'(len);
    if (state == S_VERIFY) hist_raddr = cand + AW'(vcnt);
  end

  always_comb begin
    case (vcnt)
      2'd1:    vbyte = l0;
      2'd2:    vbyte = l1;
      default: vbyte = l2;
    endcase
  end

  // Memories: synchronous read, read-first on the hash table
  always_ff @(posedge clock) begin
    hash_rd_p1 <= hash_mem[hash_addr];
    if (hash_we) hash_mem[hash_addr] <= hash_wdata;
  end

  always_ff @(posedge clock) begin
    hist_rd_p1 <= hist_mem[hist_raddr];
    if (hist_we) hist_mem[pos] <= in_byte;
  end

  // Lookahead and match bookkeeping (data only)
  always_ff @(posedge clock) begin
    if (state == S_FILL && in_valid) begin
      case (cnt)
        2'd0:    l0 <= in_byte;
        2'd1:    l1 <= in_byte;
        default: l2 <= in_byte;
      endcase
    end
    if ((state == S_EMIT_LIT || state == S_DRAIN) && out_valid && out_ready) begin
      l0 <= l1;
      l1 <= l2;
    end
    if (state == S_HASH) start <= pos - AW'(3);
    if (state == S_CHECK) begin
      cand   <= hash_pos;
      offset <= start - hash_pos;
    end
  end

  // Control FSM with registered token outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_CLEAR;
      clr_idx     <= '0;
      pos         <= '0;
      cnt         <= 2'd0;
      vcnt        <= 2'd0;
      len         <= 4'd0;
      last_seen   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 16'h0000;
      out_control <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (accept) pos <= pos + AW'(1);
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= S_FILL;
        end
        S_FILL: begin
          if (in_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd2) begin
              last_seen <= in_last;
              state     <= S_HASH;
            end else if (in_last) begin
              last_seen <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end
        S_HASH: state <= S_CHECK;
        S_CHECK: begin
          vcnt <= 2'd0;
          // A zero offset means the entry points at this very position after a full wrap.
          if (!hash_hit || hash_pos == start) state <= S_EMIT_LIT;
          else state <= S_VERIFY;
        end
        S_VERIFY: begin
          if (vcnt != 2'd0 && hist_rd_p1 != vbyte) begin
            state <= S_EMIT_LIT;
          end else if (vcnt == 2'(MIN_MATCH)) begin
            len   <= MIN_LEN;
            state <= S_EXT_ADDR;
          end else begin
            vcnt <= vcnt + 2'd1;
          end
        end
        S_EXT_ADDR: begin
          if (len == 4'd15 || last_seen) state <= S_EMIT_MATCH;
          else state <= S_EXTEND;
        end
        S_EXTEND: begin
          if (in_valid) begin
            if (hist_match) begin
              len <= len + 4'd1;
              if (in_last) last_seen <= 1'b1;
              state <= S_EXT_ADDR;
            end else begin
              state <= S_EMIT_MATCH;
            end
          end
        end
        S_EMIT_LIT: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_data    <= {8'h00, l0};
            out_control <= 1'b0;
            out_last    <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt - 2'd1;
            state     <= last_seen ? S_DRAIN : S_FILL;
          end
        end
        S_EMIT_MATCH: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_data    <= {len, 12'(offset)};
            out_control <= 1'b1;
            out_last    <= last_seen;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= 2'd0;
            state     <= last_seen ? S_DONE : S_FILL;
          end
        end
        S_DRAIN: begin
          if (cnt == 2'd0) begin
            state <= S_DONE;
          end else if (!out_valid) begin
            out_valid   <= 1'b1;
            out_data    <= {8'h00, l0};
            out_control <= 1'b0;
            out_last    <= (cnt == 2'd1);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt - 2'd1;
            if (cnt == 2'd1) state <= S_DONE;
          end
        end
        S_DONE: begin
          last_seen <= 1'b0;
          cnt       <= 2'd0;
          state     <= S_FILL;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

`ifdef LZRW1_COMP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_literals <= 32'd0;
      stat_copies   <= 32'd0;
      stat_bytes_in <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_control) stat_copies <= sat_inc(stat_copies);
        else stat_literals <= sat_inc(stat_literals);
      end
      if (accept) stat_bytes_in <= sat_inc(stat_bytes_in);
    end
  end
`endif

endmodule

// File: tb/tb_lzrw1_compressor_core.sv
// Directed-vector bench for lzrw1_compressor_core: token streams, back-pressure and mid-run reset.
module tb_lzrw1_compressor_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_control;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef LZRW1_COMP_STATS_EN
  logic [31:0] stat_literals;
  logic [31:0] stat_copies;
  logic [31:0] stat_bytes_in;
`endif

  lzrw1_compressor_core dut (
    .clock       (clock),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_control (out_control),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef LZRW1_COMP_STATS_EN
    ,
    .stat_literals (stat_literals),
    .stat_copies   (stat_copies),
    .stat_bytes_in (stat_bytes_in)
`endif
  );

  always #5 clock = ~clock;

  // One stream: up to 20 input bytes, up to 6 expected tokens {last, control, data}.
  typedef struct packed {
    logic [4:0]   nbytes;
    logic [159:0] bytes;
    logic [2:0]   ntok;
    logic [107:0] toks;
  } vec_t;

  vec_t        vecs [5];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  feed_q [$];
  logic [17:0] got_q [$];
  bit          feed_last;
  int          stall_left;
  int          exp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string s);
    vecs[i] = '0;
    vecs[i].nbytes = 5'(s.len());
    for (int j = 0; j < s.len(); j++) vecs[i].bytes[j*8 +: 8] = s[j];
  endtask

  task automatic add_tok(input int i, input logic last, input logic ctrl, input logic [15:0] d);
    vecs[i].toks[int'(vecs[i].ntok)*18 +: 18] = {last, ctrl, d};
    vecs[i].ntok = vecs[i].ntok + 3'd1;
  endtask

  task automatic load_feed(input int i);
    feed_q.delete();
    for (int j = 0; j < int'(vecs[i].nbytes); j++) feed_q.push_back(vecs[i].bytes[j*8 +: 8]);
  endtask

  task automatic feed();
    for (int i = 0; i < feed_q.size(); i++) begin
      int to;
      to = 0;
      in_byte  = feed_q[i];
      in_last  = feed_last && (i == feed_q.size() - 1);
      in_valid = 1'b1;
      #1;
      while (!in_ready && to < 3000) begin
        @(negedge clock);
        #1;
        to++;
      end
      if (to >= 3000) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: byte %0d not accepted, required acceptance", i);
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect();
    int cyc;
    int tail;
    cyc  = 0;
    tail = 0;
    got_q.delete();
    while (cyc < 6000 && tail < 30) begin
      @(negedge clock);
      cyc++;
      if (stall_left > 0 && out_valid && out_control) begin
        out_ready = 1'b0;
        stall_left--;
        chk("stall_data", 32'(out_data), 32'h3003);
      end else begin
        out_ready = 1'b1;
        if (out_valid) got_q.push_back({out_last, out_control, out_data});
      end
      if (got_q.size() >= exp_n) tail++;
    end
  endtask

  task automatic check_tokens(input int i, input int n, input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      logic [17:0] e;
      e = vecs[i].toks[j*18 +: 18];
      if (j < got_q.size()) chk($sformatf("%s_tok%0d", tag, j), 32'(got_q[j]), 32'(e));
    end
  endtask

  task automatic run_vec(input int i, input int stall, input bit last, input int n, input string tag);
    load_feed(i);
    feed_last  = last;
    stall_left = stall;
    exp_n      = n;
    fork
      feed();
      collect();
    join
    check_tokens(i, n, tag);
  endtask

  task automatic do_reset();
    int cnt;
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_control", 32'(out_control), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt   = 0;
    while (!in_ready && cnt < 2000) begin
      cnt++;
      @(negedge clock);
    end
    chk("clear_cycles", 32'(cnt), 32'd1024);
  endtask

  initial begin
    reset      = 1'b1;
    in_byte    = 8'h00;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    stall_left = 0;
    feed_last  = 1'b1;
    exp_n      = 0;

    set_vec(0, "ABC");
    add_tok(0, 1'b0, 1'b0, 16'h0041);
    add_tok(0, 1'b0, 1'b0, 16'h0042);
    add_tok(0, 1'b1, 1'b0, 16'h0043);
    set_vec(1, "ABCABC");
    add_tok(1, 1'b0, 1'b0, 16'h0041);
    add_tok(1, 1'b0, 1'b0, 16'h0042);
    add_tok(1, 1'b0, 1'b0, 16'h0043);
    add_tok(1, 1'b1, 1'b1, 16'h3003);
    set_vec(2, "AAAAAAAAAAAAAAAAAAAA");
    add_tok(2, 1'b0, 1'b0, 16'h0041);
    add_tok(2, 1'b0, 1'b1, 16'hF001);
    add_tok(2, 1'b1, 1'b1, 16'h400F);
    set_vec(3, "ABCABCX");
    add_tok(3, 1'b0, 1'b0, 16'h0041);
    add_tok(3, 1'b0, 1'b0, 16'h0042);
    add_tok(3, 1'b0, 1'b0, 16'h0043);
    add_tok(3, 1'b0, 1'b1, 16'h3003);
    add_tok(3, 1'b1, 1'b0, 16'h0058);
    set_vec(4, "ABCD");
    add_tok(4, 1'b0, 1'b0, 16'h0041);
    add_tok(4, 1'b0, 1'b0, 16'h0042);
    add_tok(4, 1'b0, 1'b0, 16'h0043);
    add_tok(4, 1'b1, 1'b0, 16'h0044);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_vec(i, 0, 1'b1, int'(vecs[i].ntok), $sformatf("vec%0d", i));
    end

    // Copy token held under back-pressure for 5 cycles
    do_reset();
    run_vec(1, 5, 1'b1, 4, "stall");
    chk("stall_cycles_used", 32'(stall_left), 32'd0);

    // Reset while waiting in EXTEND
    do_reset();
    run_vec(1, 0, 1'b0, 3, "noend");
    repeat (10) @(negedge clock);
    in_byte  = 8'h41;
    in_valid = 1'b1;
    #1;
    chk("extend_ready", 32'(in_ready), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ext_rst_out_valid", 32'(out_valid), 32'd0);
    chk("ext_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Reset while a literal is being held
    do_reset();
    out_ready = 1'b0;
    feed_last = 1'b1;
    load_feed(0);
    feed();
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clock);
    chk("pend_valid", 32'(out_valid), 32'd1);
    chk("pend_data", 32'(out_data), 32'h0041);
    #2;
    reset = 1'b1;
    #1;
    chk("pend_rst_out_valid", 32'(out_valid), 32'd0);
    chk("pend_rst_out_data", 32'(out_data), 32'd0);

    // After a fresh CLEAR no stale match may survive
    do_reset();
    run_vec(1, 0, 1'b1, 4, "after_rst");
`ifdef LZRW1_COMP_STATS_EN
    chk("stat_literals", stat_literals, 32'd3);
    chk("stat_copies", stat_copies, 32'd1);
    chk("stat_bytes_in", stat_bytes_in, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzrw1_compressor_core.md
Name: lzrw1_compressor_core

Overview:
- Byte-serial LZRW1 compressor. It is the encoding counterpart of the team's decompressor.
- Accepts a raw byte stream and emits 16-bit tokens plus a control bit in the format the decompressor consumes:
  - literal: control 0, data {8'h00, byte}
  - copy: control 1, data {length[3:0], offset[11:0]}
- Finds matches with a direct-mapped hash table and a ring history buffer of the same size as the decompressor's.

Parameters:
- HISTORY_SIZE, 4096, ring history depth in bytes; must equal the decompressor setting; offset field is 12 bits.
- HASH_BITS, 10, log2 of hash-table entries; range 1..12.
- MIN_MATCH, 3, shortest match emitted as a copy token; fixed at 3.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_byte  in  8  raw input byte
- in_valid  in  1  in_byte is valid
- in_last  in  1  qualifies in_byte as the final byte of the stream
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  16  token data
- out_control  out  1  0 = literal, 1 = copy
- out_last  out  1  final token of the stream
- out_valid  out  1  token valid
- out_ready  in  1  sink accepts the token (tie to ~decompressor_busy in loopback)

Behaviour:
- Reset (asynchronous, active-high; clock is clock):
  - out_valid, out_data, out_control, out_last, in_ready = 0
  - pos = 0, lookahead empty, state CLEAR
- pos: HISTORY_ADDR_WIDTH-bit write pointer, wraps HISTORY_SIZE-1 -> 0. Every accepted byte is written to history[pos], then pos++.
- Hash: h = low HASH_BITS of ({b0,4'b0} ^ {2'b0,b1,2'b0} ^ {4'b0,b2}). Each entry holds {valid, position}.
- RAMs: both history and hash table have a 1-cycle synchronous read.
- CLEAR: walks all 2^HASH_BITS entries, one per cycle, writing valid = 0; in_ready = 0 throughout; then -> FILL.
- FILL:
  - in_ready = 1; shifts bytes into lookahead L0..L2.
  - 3 held -> HASH. in_last accepted with <3 held -> DRAIN.
  - in_last accepted as the 3rd byte: flag last_seen, -> HASH.
- HASH:
  - start = position of L0; read entry[h(L0,L1,L2)]; write entry = {1, start}.
  - Read and write are the same cycle; read returns the old value. -> CHECK.
- CHECK:
  - Entry invalid -> EMIT_LIT.
  - Otherwise cand = entry.position, offset = (start - cand) mod HISTORY_SIZE; offset == 0 -> EMIT_LIT, else -> VERIFY.
- VERIFY:
  - Reads history[cand+k] for k = 0..2 and compares with Lk.
  - Any mismatch -> EMIT_LIT. All equal -> len = 3, -> EXTEND.
- EXTEND:
  - len == 15 or last_seen -> EMIT_MATCH.
  - Otherwise reads history[cand+len] and waits for in_valid.
  - in_ready = in_valid && (in_byte == read byte). Combinational dependence on valid/data is permitted.
  - Match: accept, write history, len++; an accepted in_last sets last_seen.
  - Mismatch: byte not consumed, -> EMIT_MATCH; the byte becomes L0 of the next FILL.
- EMIT_LIT:
  - Token {8'h00, L0}, control 0. Hold until out_ready.
  - Then shift L0 <- L1 <- L2. -> FILL if !last_seen, else DRAIN.
- EMIT_MATCH:
  - Token {len[3:0], offset[11:0]}, control 1; out_last = last_seen.
  - Hold until out_ready. Lookahead emptied; -> FILL, or -> DONE if last_seen.
- DRAIN: each remaining lookahead byte goes out as a literal; out_last = 1 on the final one; then -> DONE.
- DONE: clears last_seen, -> FILL. Hash table, history and pos persist across streams, matching the decompressor.
- Output rules:
  - out_* registered and stable while out_valid && !out_ready.
  - in_ready = 0 in every state except FILL and EXTEND.
- Wrap-around: all history addresses (cand+k, pos) are modulo HISTORY_SIZE.
- Aliasing: stale or aliased hash entries are harmless because VERIFY compares actual bytes.
- Reset mid-operation aborts any token (out_valid drops immediately) and re-enters CLEAR.

Optional Feature:
- Macro: LZRW1_COMP_STATS_EN.
- Defined: adds outputs stat_literals[31:0] and stat_copies[31:0] and a saturating counter stat_bytes_in[31:0].
  - Each counts on its handshake: literal accepted, copy accepted, input byte accepted.
  - Cleared by reset only.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After reset -> in_ready = 0 for exactly 1024 cycles (HASH_BITS = 10), then 1.
- "ABC", in_last on C -> three literals 0x0041, 0x0042, 0x0043, control 0; out_last only on 0x0043.
- "ABCABC" with last -> literals 0x0041, 0x0042, 0x0043, then copy 0x3003 (len 3, offset 3), control 1, out_last = 1.
- 20 x 'A' with last -> literal 0x0041, copy 0xF001, copy 0x400F with out_last. Decompressor loopback reproduces the 20 bytes.
- "ABCABC", out_ready held low 5 cycles on the copy -> out_data 0x3003 stable; single acceptance; no duplicate token.
- Reset asserted during EXTEND -> out_valid = 0 same cycle. After CLEAR, "ABCABC" gives the same tokens as the fresh case (no stale match). With LZRW1_COMP_STATS_EN, counters read literals = 3, copies = 1, bytes_in = 6.
